// File: rtl/load_store_unit_if.sv
// Signal bundle between the load/store unit, the execute/writeback stages and the data RAM.
// master = the LSU itself; slave = everything around it (pipeline stages and RAM).
interface load_store_unit_if;
    // Handshakes: a transfer happens on the rising edge where valid && ready are both high.
    // valid never waits for ready, and the payload stays stable while valid is high.
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] resp_addr;

    logic        mem_read_en;
    logic        mem_write_en;
    logic [2:0]  mem_load_type;
    logic [2:0]  mem_store_type;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_busy;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err, resp_addr,
        input  resp_ready,
        output mem_read_en, mem_write_en, mem_load_type, mem_store_type, mem_address, mem_data_in,
        input  mem_data_out, mem_busy
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err, resp_addr,
        output resp_ready,
        input  mem_read_en, mem_write_en, mem_load_type, mem_store_type, mem_address, mem_data_in,
        output mem_data_out, mem_busy
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store unit: computes base+offset, screens the access, runs a
// one-cycle RAM strobe, normalises load data and holds the response until accepted.
module load_store_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    load_store_unit_if.master         bus,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic [31:0] ea_c;
    logic        illegal_c;
    logic        misaligned_c;
    logic        out_of_range_c;
    logic [1:0]  err_c;
    logic        is_store_q;
    logic [31:0] rdata_norm;

    assign bus.req_ready = rst_n && (state_q == IDLE) && !bus.mem_busy;
    assign accept        = bus.req_valid && bus.req_ready;
    assign ea_c          = bus.req_base + bus.req_offset;
    assign dbg_state     = state_q;

    // funct3[1:0] encodes the access size for every legal load/store code.
    always_comb begin
        illegal_c      = 1'b0;
        misaligned_c   = 1'b0;
        out_of_range_c = 1'b0;
        err_c          = 2'b00;
        if (bus.req_is_store) begin
            illegal_c = (bus.req_funct3 > 3'b010);
        end else begin
            illegal_c = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                        (bus.req_funct3 == 3'b111);
        end
        misaligned_c   = ((bus.req_funct3[1:0] == 2'b01) && ea_c[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));
        out_of_range_c = (ea_c >= MEM_LIMIT);
        if (illegal_c) begin
            err_c = 2'b11;
        end else if (misaligned_c) begin
            err_c = 2'b01;
        end else if (out_of_range_c) begin
            err_c = 2'b10;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (err_c != 2'b00) ? RESP : ACCESS;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAM returns sign-extended sub-word data; unsigned loads clear the upper bits here.
    always_comb begin
        rdata_norm = bus.mem_data_out;
        case (bus.mem_load_type)
            3'b100:  rdata_norm = {24'h0, bus.mem_data_out[7:0]};
            3'b101:  rdata_norm = {16'h0, bus.mem_data_out[15:0]};
            default: rdata_norm = bus.mem_data_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q         <= 1'b0;
            bus.resp_valid     <= 1'b0;
            bus.resp_rdata     <= 32'h0;
            bus.resp_err       <= 2'b00;
            bus.resp_addr      <= 32'h0;
            bus.mem_read_en    <= 1'b0;
            bus.mem_write_en   <= 1'b0;
            bus.mem_load_type  <= 3'b000;
            bus.mem_store_type <= 3'b000;
            bus.mem_address    <= 32'h0;
            bus.mem_data_in    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_store_q <= bus.req_is_store;
                        if (err_c != 2'b00) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= err_c;
                            bus.resp_rdata <= 32'h0;
                            bus.resp_addr  <= ea_c;
                        end else begin
                            // mem_address/type/data double as the latched request for CAPTURE.
                            bus.mem_read_en    <= !bus.req_is_store;
                            bus.mem_write_en   <= bus.req_is_store;
                            bus.mem_address    <= ea_c;
                            bus.mem_load_type  <= bus.req_funct3;
                            bus.mem_store_type <= bus.req_funct3;
                            bus.mem_data_in    <= bus.req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    bus.mem_read_en  <= 1'b0;
                    bus.mem_write_en <= 1'b0;
                end
                CAPTURE: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 2'b00;
                    bus.resp_addr  <= bus.mem_address;
                    bus.resp_rdata <= is_store_q ? 32'h0 : rdata_norm;
                end
                RESP: begin
                    if (bus.resp_ready) bus.resp_valid <= 1'b0;
                end
                default: begin
                    bus.resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the word-organised data RAM.
- Accepts one load/store request at a time from the execute stage and computes the effective address as base + offset.
- Checks funct3 legality, alignment and range, then drives the RAM's one-cycle read/write strobe and width codes.
- Captures and normalises read data, then returns a response with backpressure to writeback.

Parameters:
MEM_BYTES, 4096, size of the data RAM in bytes; any effective address >= MEM_BYTES is out of range.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request offered
req_ready  output  1  LSU can accept a request this cycle
req_is_store  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
req_base  input  32  rs1 value
req_offset  input  32  sign-extended immediate
req_wdata  input  32  rs2 value (store data, unshifted)
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  load result (0 for stores and faults)
resp_err  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
resp_addr  output  32  effective address of the completed request
mem_read_en  output  1  RAM read strobe
mem_write_en  output  1  RAM write strobe
mem_load_type  output  3  RAM load width code (= funct3)
mem_store_type  output  3  RAM store width code (= funct3)
mem_address  output  32  RAM byte address
mem_data_in  output  32  RAM write data (= req_wdata; RAM does lane placement)
mem_data_out  input  32  RAM registered read data
mem_busy  input  1  RAM busy flag

Behaviour:
- Reset (async, rst_n low): state IDLE. req_ready=0 while in reset. All registered outputs are 0: resp_valid, resp_rdata, resp_err, resp_addr, mem_read_en, mem_write_en, mem_load_type, mem_store_type, mem_address, mem_data_in.
- States: IDLE, ACCESS, CAPTURE, RESP.
- req_ready = (state==IDLE) && !mem_busy. This is combinational.
- IDLE, on req_valid && req_ready:
  - Compute ea = req_base + req_offset, modulo 2^32, wrap ignored.
  - Latch ea, funct3, is_store and wdata.
  - Classify, first match wins:
    - illegal: load funct3 in {011,110,111}, or store funct3 >= 011.
    - misaligned: halfword with ea[0]=1, or word with ea[1:0]!=00.
    - out of range: ea >= MEM_BYTES.
  - Fault: go to RESP with resp_err set, resp_rdata=0, resp_addr=ea. No strobe is ever asserted.
  - OK: go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_read_en = !is_store, mem_write_en = is_store.
  - mem_address = ea, mem_load_type = mem_store_type = funct3, mem_data_in = wdata. Address, type and data stay stable through CAPTURE.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - Both strobes are 0.
  - The RAM output sampled at the ACCESS edge is now valid.
  - Load: resp_rdata <= mem_data_out, normalised:
    - LBU: bits[31:8] forced to 0.
    - LHU: bits[31:16] forced to 0.
    - LB, LH, LW: passed unchanged.
  - Store: resp_rdata <= 0.
  - resp_err <= 00, resp_addr <= ea. Go to RESP.
- RESP:
  - resp_valid=1. Hold all resp_* stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid <= 0, go to IDLE.
  - No new request is accepted in the same cycle.
- Latency (resp_ready tied high):
  - Legal access: request accepted at edge N, resp_valid high in the cycle after edge N+2. Minimum 4-cycle initiation interval.
  - Fault: resp_valid high in the cycle after edge N.
- Strobes are never asserted for more than one cycle per request. They are never both high.
- mem_busy high in IDLE blocks acceptance and does not affect other states.
- Reset mid-operation returns to IDLE immediately and drops any response.
  - A write already sampled by the RAM at an ACCESS edge stays committed.
  - A strobe cut by reset before its edge is not performed.

Test Plan:
- LW, base=0x100, offset=0x4: RAM word 0x104 = 0xDEADBEEF -> one-cycle mem_read_en, mem_address=0x104, mem_load_type=010; resp_rdata=0xDEADBEEF, resp_err=00, resp_addr=0x104, resp_valid 3 cycles after accept.
- SB 0xA5 to 0x202, then LBU 0x202 and LB 0x202 -> mem_write_en one cycle with mem_store_type=000; LBU returns 0x000000A5; LB returns 0xFFFFFFA5.
- LH at 0x101, SW at 0x102, LW base=0xFFC, offset=0x8 (ea=0x1004) with MEM_BYTES=4096 -> resp_err 01, 01, 10; no strobe ever high; resp_valid 1 cycle after accept.
- Load funct3=011 at misaligned 0x3 -> resp_err=11 (illegal beats misaligned), resp_rdata=0.
- LW with resp_ready held low 5 cycles -> resp_valid and resp_rdata stable for all 5, req_ready=0 throughout; accepted on the 6th cycle, then back to IDLE.
- rst_n pulsed low during ACCESS of an SW 0x12345678 to 0x40 -> all outputs 0 asynchronously and state IDLE; a following LW 0x40 returns the pre-existing value. Repeat with reset asserted in CAPTURE -> LW 0x40 returns 0x12345678.
